batch_result_drain: RTL and testbench
=====================================

BATCH_RESULT_DRAIN -- requirements
Module: batch_result_drain

Interface
REQ-001 SHALL have parameter out_w, default 16, width of one filter result word.
REQ-002 SHALL have parameter depth, default 16, FIFO entries; power of two, at least 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in  input  out_w  result word from the batch filter.
REQ-006 SHALL have port valid  input  1  in carries a new result this cycle.
REQ-007 SHALL have port clr  input  1  synchronous flush plus sticky-flag clear.
REQ-008 SHALL have port out_data  output  out_w  head-of-FIFO word.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port level  output  $clog2(depth)+1  current occupancy, 0..depth.
REQ-012 SHALL have port ovf  output  1  sticky flag: at least one result dropped.

Function
REQ-013 SHALL define push = valid & (level<depth | pop) & !clr, and pop = out_valid & out_ready & !clr.
REQ-014 SHALL make a word pushed in cycle t appear on out_data with out_valid=1 in cycle t+1 when the FIFO was empty, giving first-word-fall-through behaviour with 1-cycle latency.
REQ-015 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-016 SHALL present words in arrival order, bit-exact, with no width conversion.
REQ-017 SHALL implement a state machine with states EMPTY, ACTIVE, FULL and OVF, where OVF means the FIFO is non-full and ovf=1.
REQ-018 SHALL take these state transitions:
- EMPTY->ACTIVE on push.
- ACTIVE->FULL when level reaches depth.
- FULL->ACTIVE on a pop with no push.
- ACTIVE->EMPTY when level reaches 0.
- any state->EMPTY on clr.
REQ-019 SHALL, at full with valid=1 and pop=1 in the same cycle, accept the word; level stays depth and nothing is dropped.
REQ-020 SHALL, at full with valid=1 and pop=0, drop the word, leave FIFO contents unchanged and set ovf=1 from the next cycle.
REQ-021 SHALL, when empty, ignore out_ready; pop never underflows.
REQ-022 SHALL wrap the read and write pointers modulo depth without error at every wrap point.
REQ-023 SHALL, on clr=1, make level=0, out_valid=0 and ovf=0 in the next cycle; clr wins over a simultaneous valid or out_ready.
REQ-024 SHALL keep ovf set until clr or reset.

Reset
REQ-025 SHALL, while rst=0, force level=0, out_valid=0, ovf=0, out_data=0, both pointers to 0 and the state to EMPTY, regardless of clk.
REQ-026 SHALL discard stored words on a reset during operation; no stale word reaches out_valid after reset releases.
REQ-027 SHALL accept a push in the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, when DRAIN_STATS_EN is defined, add output drop_cnt (16 bits). It counts words dropped per REQ-020, saturates at 16'hFFFF, and clears on clr or reset.
REQ-029 SHALL, when DRAIN_STATS_EN is undefined, have no drop_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover this scenario: push 0x1234 into an empty FIFO with out_ready=1 -> out_data=0x1234 and out_valid=1 exactly one cycle later, and level returns to 0.
REQ-031 SHALL cover this scenario: out_ready=0, push 17 words 0..16 with depth=16 -> level=16, ovf=1, word 16 is lost, and draining returns 0..15 in order; with DRAIN_STATS_EN, drop_cnt=1.
REQ-032 SHALL cover this scenario: fill to 16, then hold valid=1 and out_ready=1 for 40 cycles -> level stays 16, ovf stays 0, and the output sequence is continuous through pointer wrap.
REQ-033 SHALL cover this scenario: fill 5 words, stall out_ready=0 for 10 cycles -> out_data is held at the first word for all 10 cycles.
REQ-034 SHALL cover this scenario: with level=8 and ovf=1, assert clr together with valid=1 -> next cycle level=0, out_valid=0, ovf=0, and the coincident word is discarded.
REQ-035 SHALL cover this scenario: assert rst=0 mid-stream with level=6, asynchronous to clk -> all outputs are 0 immediately, and the first post-reset push appears after one cycle.

Source files
------------

// File: rtl/batch_result_drain.sv
// batch_result_drain
//   First-word-fall-through result FIFO that drains batch filter results to a
//   ready/valid consumer. Words that arrive while the FIFO is full (and nothing
//   is leaving) are dropped and recorded in a sticky overflow flag.
//
//   Parameters
//     out_w      width of one result word
//     depth      FIFO entries (power of two, >= 4)
//
//   Ports
//     clk        sole clock, rising edge
//     rst        asynchronous active-low reset
//     in         result word from the batch filter
//     valid      in carries a new result this cycle
//     clr        synchronous flush + sticky flag clear (wins over valid/out_ready)
//     out_data   head-of-FIFO word (0 while out_valid=0)
//     out_valid  out_data holds a valid word
//     out_ready  downstream accepts out_data this cycle
//     level      current occupancy, 0..depth
//     ovf        sticky: at least one result dropped
//     drop_cnt   (DRAIN_STATS_EN only) saturating count of dropped words
//
//   Build option: define DRAIN_STATS_EN to add the drop_cnt port and counter.

module batch_result_drain #(
    parameter int out_w = 16,
    parameter int depth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [out_w-1:0]           in,
    input  logic                       valid,
    input  logic                       clr,
    output logic [out_w-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(depth):0]     level,
    output logic                       ovf
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int AW = $clog2(depth);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_OVF    = 2'd3;

    logic [out_w-1:0] mem_q [depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic [1:0]    state_q,  state_d;

    logic full;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        full      = (state_q == ST_FULL);
        out_valid = (level_q != '0);
        pop       = out_valid & out_ready & ~clr;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = valid & (~full | pop) & ~clr;
        drop      = valid & full & ~pop & ~clr;

        level_d  = level_q + LW'(push) - LW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        ovf_d    = ovf_q | drop;

        if (clr) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end

        // State follows the next occupancy/flag; a non-full FIFO with the
        // sticky flag set sits in OVF (including when drained to empty).
        if (clr)
            state_d = ST_EMPTY;
        else if (level_d == LW'(depth))
            state_d = ST_FULL;
        else if (ovf_d)
            state_d = ST_OVF;
        else if (level_d == '0)
            state_d = ST_EMPTY;
        else
            state_d = ST_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // Storage carries no reset; out_valid gates every read so stale contents
    // are never visible.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in;
    end

    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign ovf      = ovf_q;

`ifdef DRAIN_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr)
            drop_cnt_d = '0;
        else if (drop && drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_batch_result_drain.sv
module tb_batch_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_w;
    logic        valid;
    logic        clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        ovf;
`ifdef DRAIN_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    batch_result_drain #(.out_w(16), .depth(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_w),
        .valid     (valid),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf)
`ifdef DRAIN_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven at this point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_w = '0; valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
        #3;
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || out_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: level=%0d out_valid=%b ovf=%b out_data=%h, want 0/0/0/0000",
                     level, out_valid, ovf, out_data);
        end
        tick();
        tick();
    endtask

    // Push 0x1234 on the first edge after reset release, ready held high.
    task automatic test_single();
        rst = 1'b1;
        in_w = 16'h1234; valid = 1'b1; out_ready = 1'b1;
        tick();
        valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 5'd1) begin
            miscompares++;
            $display("FAIL single_latency: out_valid=%b out_data=%h level=%0d, want 1/1234/1",
                     out_valid, out_data, level);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL single_drain: out_valid=%b level=%0d, want 0/0", out_valid, level);
        end
        // Ready while empty must not underflow.
        tick();
        tick();
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_underflow: level=%0d out_valid=%b, want 0/0", level, out_valid);
        end
    endtask

    // 17 pushes into depth 16 with no drain: word 16 dropped, order preserved.
    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_w = 16'(i); valid = 1'b1;
            tick();
            if (i == 15) begin
                vectors++;
                if (level !== 5'd16 || ovf !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fill_16: level=%0d ovf=%b, want 16/0", level, ovf);
                end
            end
        end
        valid = 1'b0;
        vectors++;
        if (level !== 5'd16 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: level=%0d ovf=%b, want 16/1", level, ovf);
        end
`ifdef DRAIN_STATS_EN
        vectors++;
        if (drop_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL drop_cnt_one: got %0d, want 1", drop_cnt);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                miscompares++;
                $display("FAIL overflow_drain[%0d]: out_valid=%b out_data=%h, want 1/%h",
                         i, out_valid, out_data, 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: level=%0d out_valid=%b ovf=%b, want 0/0/1",
                     level, out_valid, ovf);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_ovf: ovf=%b, want 0", ovf);
        end
    endtask

    // Full FIFO with simultaneous push and pop for 40 cycles crosses the wrap.
    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_w = 16'h0100 + 16'(i); valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_w = 16'h0110 + 16'(k);
            vectors++;
            if (out_data !== 16'h0100 + 16'(k)) begin
                miscompares++;
                $display("FAIL b2b_data[%0d]: got %h, want %h", k, out_data, 16'h0100 + 16'(k));
            end
            tick();
            vectors++;
            if (level !== 5'd16 || ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_level[%0d]: level=%0d ovf=%b, want 16/0", k, level, ovf);
            end
        end
        valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'h0128 + 16'(k)) begin
                miscompares++;
                $display("FAIL b2b_tail[%0d]: out_valid=%b out_data=%h, want 1/%h",
                         k, out_valid, out_data, 16'h0128 + 16'(k));
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (level !== 5'd0) begin
            miscompares++;
            $display("FAIL b2b_empty: level=%0d, want 0", level);
        end
    endtask

    // Head word must hold while downstream stalls.
    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_w = 16'h00A0 + 16'(i); valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'h00A0 || level !== 5'd5) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: out_valid=%b out_data=%h level=%0d, want 1/00a0/5",
                         c, out_valid, out_data, level);
            end
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // clr together with valid at level 8 / ovf 1: everything flushed.
    task automatic test_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_w = 16'h0200 + 16'(i); valid = 1'b1;
            tick();
        end
        valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        vectors++;
        if (level !== 5'd8 || ovf !== 1'b1 || out_data !== 16'h0208) begin
            miscompares++;
            $display("FAIL clr_setup: level=%0d ovf=%b out_data=%h, want 8/1/0208",
                     level, ovf, out_data);
        end
        clr = 1'b1; valid = 1'b1; in_w = 16'hDEAD; out_ready = 1'b1;
        tick();
        clr = 1'b0; valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || out_data !== 16'h0) begin
            miscompares++;
            $display("FAIL clr_flush: level=%0d out_valid=%b ovf=%b out_data=%h, want 0/0/0/0000",
                     level, out_valid, ovf, out_data);
        end
`ifdef DRAIN_STATS_EN
        vectors++;
        if (drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL clr_drop_cnt: got %0d, want 0", drop_cnt);
        end
`endif
        tick();
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_discard: level=%0d out_valid=%b, want 0/0", level, out_valid);
        end
    endtask

    // Asynchronous reset mid-stream at level 6, then a fresh push.
    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_w = 16'h0300 + 16'(i); valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        vectors++;
        if (level !== 5'd6) begin
            miscompares++;
            $display("FAIL arst_setup: level=%0d, want 6", level);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (level !== 5'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || out_data !== 16'h0) begin
            miscompares++;
            $display("FAIL arst_immediate: level=%0d out_valid=%b ovf=%b out_data=%h, want 0/0/0/0000",
                     level, out_valid, ovf, out_data);
        end
        tick();
        #2;
        rst = 1'b1;
        in_w = 16'h0055; valid = 1'b1; out_ready = 1'b0;
        tick();
        valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 16'h0055 || level !== 5'd1) begin
            miscompares++;
            $display("FAIL arst_first_push: out_valid=%b out_data=%h level=%0d, want 1/0055/1",
                     out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL arst_no_stale: out_valid=%b level=%0d, want 0/0", out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
